// File: rtl/render_ctrl_if.sv
// Bundle between the render controller, the game logic and the pixel datapath.
// The master side is the controller; the slave side is the game logic plus datapath.
interface render_ctrl_if #(
    parameter int OBJ_W = 2,
    parameter int PIX_W = 8
);
    logic             touch_edge;
    logic             pause;
    logic             restart;
    logic             move_en;
    logic             load_coord;
    logic             init_coord;
    logic             datapath_en;
    logic [1:0]       op;
    logic [OBJ_W-1:0] obj_sel;
    logic [PIX_W-1:0] pix_idx;
    logic             game_over;
    logic [15:0]      frame_cnt;

    modport master (
        input  touch_edge, pause, restart,
        output move_en, load_coord, init_coord, datapath_en, op,
               obj_sel, pix_idx, game_over, frame_cnt
    );

    modport slave (
        output touch_edge, pause, restart,
        input  move_en, load_coord, init_coord, datapath_en, op,
               obj_sel, pix_idx, game_over, frame_cnt
    );
endinterface

// File: rtl/render_ctrl_fsm.sv
// Multi-object frame sequencer: draw all objects, check game over, wait a frame
// period, erase all objects, advance coordinates. Outputs are registered.
module render_ctrl_fsm #(
    parameter int NUM_OBJ     = 4,
    parameter int PIX_COUNT   = 250,
    parameter int FRAME_TICKS = 1666666
) (
    input  logic          clk,
    input  logic          reset,
    render_ctrl_if.master bus
);
    localparam int OBJ_W  = (NUM_OBJ > 1)     ? $clog2(NUM_OBJ)     : 1;
    localparam int PIX_W  = (PIX_COUNT > 1)   ? $clog2(PIX_COUNT)   : 1;
    localparam int TICK_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

    localparam logic [OBJ_W-1:0]  OBJ_LAST  = OBJ_W'(NUM_OBJ - 1);
    localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(PIX_COUNT - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(FRAME_TICKS - 1);

    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_DRAW  = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_ERASE = 3'd4;
    localparam logic [2:0] S_LOAD  = 3'd5;
    localparam logic [2:0] S_OVER  = 3'd6;

    logic [2:0]        state_r, state_nxt_s;
    logic [OBJ_W-1:0]  obj_r, obj_nxt_s;
    logic [PIX_W-1:0]  pix_r, pix_nxt_s;
    logic [TICK_W-1:0] tick_r, tick_nxt_s;
    logic [15:0]       frame_cnt_r, frame_nxt_s;
    logic              pass_last_s;
    logic              in_pass_s;
    logic              move_en_r, load_coord_r, init_coord_r, datapath_en_r, game_over_r;
    logic [1:0]        op_r;
    logic              move_en_s, load_coord_s, init_coord_s, datapath_en_s, game_over_s;
    logic [1:0]        op_s;

    assign pass_last_s = (obj_r == OBJ_LAST) && (pix_r == PIX_LAST);
    assign in_pass_s   = (state_r == S_DRAW) || (state_r == S_ERASE);

    // Next-state selection; game inputs only matter in CHECK, WAIT and GAME_OVER.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_INIT:  state_nxt_s = S_DRAW;
            S_DRAW:  state_nxt_s = pass_last_s ? S_CHECK : S_DRAW;
            S_CHECK: state_nxt_s = bus.touch_edge ? S_OVER : S_WAIT;
            S_WAIT: begin
                if (!bus.pause && (tick_r == TICK_LAST)) begin
                    state_nxt_s = S_ERASE;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            S_ERASE: state_nxt_s = pass_last_s ? S_LOAD : S_ERASE;
            S_LOAD:  state_nxt_s = S_DRAW;
            S_OVER:  state_nxt_s = bus.restart ? S_INIT : S_OVER;
            default: state_nxt_s = S_INIT;
        endcase
    end

    // Pixel/object walk, wait timer and frame counter next values.
    always_comb begin
        obj_nxt_s   = '0;
        pix_nxt_s   = '0;
        tick_nxt_s  = '0;
        frame_nxt_s = frame_cnt_r;
        if (in_pass_s) begin
            if (pix_r == PIX_LAST) begin
                pix_nxt_s = '0;
                obj_nxt_s = (obj_r == OBJ_LAST) ? '0 : obj_r + OBJ_W'(1);
            end else begin
                pix_nxt_s = pix_r + PIX_W'(1);
                obj_nxt_s = obj_r;
            end
        end else begin
            pix_nxt_s = '0;
            obj_nxt_s = '0;
        end
        if (state_r == S_WAIT) begin
            if (bus.pause) begin
                tick_nxt_s = tick_r;
            end else if (tick_r == TICK_LAST) begin
                tick_nxt_s = '0;
            end else begin
                tick_nxt_s = tick_r + TICK_W'(1);
            end
        end else begin
            tick_nxt_s = '0;
        end
        // Counter reads zero during the INIT cycle itself, including after restart.
        if (state_nxt_s == S_INIT) begin
            frame_nxt_s = 16'd0;
        end else if (state_r == S_LOAD) begin
            frame_nxt_s = frame_cnt_r + 16'd1;
        end else begin
            frame_nxt_s = frame_cnt_r;
        end
    end

    // Moore output decode of the upcoming state, so the output flops track state_r.
    always_comb begin
        move_en_s     = 1'b0;
        load_coord_s  = 1'b0;
        init_coord_s  = 1'b0;
        datapath_en_s = 1'b0;
        game_over_s   = 1'b0;
        op_s          = 2'b00;
        case (state_nxt_s)
            S_INIT:  init_coord_s = 1'b1;
            S_DRAW: begin
                move_en_s     = 1'b1;
                datapath_en_s = 1'b1;
            end
            S_WAIT:  move_en_s = 1'b1;
            S_ERASE: begin
                move_en_s     = 1'b1;
                datapath_en_s = 1'b1;
                op_s          = 2'b01;
            end
            S_LOAD:  load_coord_s = 1'b1;
            S_OVER:  game_over_s = 1'b1;
            default: op_s = 2'b00;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= S_INIT;
            obj_r         <= '0;
            pix_r         <= '0;
            tick_r        <= '0;
            frame_cnt_r   <= 16'd0;
            move_en_r     <= 1'b0;
            load_coord_r  <= 1'b0;
            init_coord_r  <= 1'b1;
            datapath_en_r <= 1'b0;
            game_over_r   <= 1'b0;
            op_r          <= 2'b00;
        end else begin
            state_r       <= state_nxt_s;
            obj_r         <= obj_nxt_s;
            pix_r         <= pix_nxt_s;
            tick_r        <= tick_nxt_s;
            frame_cnt_r   <= frame_nxt_s;
            move_en_r     <= move_en_s;
            load_coord_r  <= load_coord_s;
            init_coord_r  <= init_coord_s;
            datapath_en_r <= datapath_en_s;
            game_over_r   <= game_over_s;
            op_r          <= op_s;
        end
    end

    assign bus.move_en     = move_en_r;
    assign bus.load_coord  = load_coord_r;
    assign bus.init_coord  = init_coord_r;
    assign bus.datapath_en = datapath_en_r;
    assign bus.op          = op_r;
    assign bus.obj_sel     = obj_r;
    assign bus.pix_idx     = pix_r;
    assign bus.game_over   = game_over_r;
    assign bus.frame_cnt   = frame_cnt_r;
endmodule
